sev_segment_scanner: RTL and testbench

Time-multiplexed display driver sitting directly downstream of the traffic-light top level. It takes the three decoded 7-segment glyphs for the amber countdown (tens, ones, tenths), latches one coherent snapshot per frame, and scans them onto a single shared segment bus with one anode enable per digit. Each digit slot starts with a guard interval with all anodes off to prevent ghosting. The decimal point is driven after the ones digit, and the tens digit can optionally be blanked when it is zero.

---
 rtl/sev_segment_scanner.sv | 114 +++++++++++
 tb/tb_sev_segment_scanner.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/sev_segment_scanner.sv
// Three-digit time-multiplexed 7-segment scanner.
// Latches one glyph snapshot per frame, then scans tens, ones and tenths in turn.
// Each digit slot opens with a dark guard interval.
module sev_segment_scanner #(
  parameter int DIGIT_DIV      = 50000,
  parameter int GUARD_CYCLES   = 4,
  parameter bit SEG_ACTIVE_LOW = 1'b1,
  parameter bit AN_ACTIVE_LOW  = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       blank_leading,
  input  logic [6:0] sev_segment_in [2:0],
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [2:0] an_out,
  output logic       frame_tick
);

  localparam int unsigned     CntW   = (DIGIT_DIV > 1) ? $clog2(DIGIT_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(DIGIT_DIV - 1);
  localparam logic [6:0]      SegOff = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
  localparam logic            DpOff  = SEG_ACTIVE_LOW;
  localparam logic [2:0]      AnOff  = AN_ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [6:0]      GlyphZero = 7'h3F;

  typedef enum logic [1:0] {StIdle, StGuard, StOn} state_e;

  state_e          state_q;
  logic [1:0]      slot_q, slot_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [6:0]      shadow_q [2:0];
  logic [6:0]      glyph_d  [2:0];
  logic            blank_q, blank_d;
  logic            load;
  logic            guard_d;
  logic [6:0]      seg_lit;
  logic [2:0]      an_lit;
  logic            dp_lit;
  logic            tick_d;

  // Next slot position; the frame restarts at slot 2 from idle or after slot 0 ends.
  always_comb begin
    slot_d = slot_q;
    cnt_d  = cnt_q;
    load   = 1'b0;
    if (state_q == StIdle) begin
      slot_d = 2'd2;
      cnt_d  = '0;
      load   = 1'b1;
    end else if (cnt_q == CntMax) begin
      cnt_d  = '0;
      slot_d = (slot_q == 2'd0) ? 2'd2 : slot_q - 2'd1;
      load   = (slot_q == 2'd0);
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Active-high view of what the next output cycle should show.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      glyph_d[i] = load ? sev_segment_in[i] : shadow_q[i];
    end
    blank_d = load ? blank_leading : blank_q;
    guard_d = int'(cnt_d) < GUARD_CYCLES;
    seg_lit = '0;
    unique case (slot_d)
      2'd2:    seg_lit = (blank_d && glyph_d[2] == GlyphZero) ? 7'h00 : glyph_d[2];
      2'd1:    seg_lit = glyph_d[1];
      default: seg_lit = glyph_d[0];
    endcase
    an_lit = guard_d ? 3'b000 : (3'b001 << slot_d);
    dp_lit = !guard_d && (slot_d == 2'd1);
    tick_d = (slot_d == 2'd0) && (cnt_d == CntMax);
  end

  // Scan FSM with registered outputs; disable forces idle and a dark display.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      slot_q     <= 2'd2;
      cnt_q      <= '0;
      shadow_q   <= '{default: '0};
      blank_q    <= 1'b0;
      seg_out    <= SegOff;
      dp_out     <= DpOff;
      an_out     <= AnOff;
      frame_tick <= 1'b0;
    end else if (!enable) begin
      state_q    <= StIdle;
      slot_q     <= 2'd2;
      cnt_q      <= '0;
      seg_out    <= SegOff;
      dp_out     <= DpOff;
      an_out     <= AnOff;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= guard_d ? StGuard : StOn;
      slot_q     <= slot_d;
      cnt_q      <= cnt_d;
      if (load) begin
        shadow_q <= sev_segment_in;
        blank_q  <= blank_leading;
      end
      seg_out    <= guard_d ? SegOff : (SegOff ^ seg_lit);
      dp_out     <= DpOff ^ dp_lit;
      an_out     <= AnOff ^ an_lit;
      frame_tick <= tick_d;
    end
  end

endmodule

// File: tb/tb_sev_segment_scanner.sv
// Scoreboard bench for sev_segment_scanner (DIGIT_DIV=8, GUARD_CYCLES=2, active-low).
module tb_sev_segment_scanner;

  localparam int WinLo = 160;
  localparam int WinHi = 399;

  typedef struct {
    int         cyc;
    logic [6:0] seg;
    logic       dp;
    logic [2:0] an;
    logic       tick;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       enable;
  logic       blank_leading;
  logic [6:0] glyph [2:0];
  logic [6:0] seg_out;
  logic       dp_out;
  logic [2:0] an_out;
  logic       frame_tick;

  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   multi_an = 0;
  int   ticks = 0;
  exp_t q[$];
  exp_t mon_e;

  sev_segment_scanner #(
    .DIGIT_DIV     (8),
    .GUARD_CYCLES  (2),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .blank_leading (blank_leading),
    .sev_segment_in(glyph),
    .seg_out       (seg_out),
    .dp_out        (dp_out),
    .an_out        (an_out),
    .frame_tick    (frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got != want) begin
      failures++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic push_idle(input int c);
    exp_t e;
    e.cyc = c; e.seg = 7'h7F; e.dp = 1'b1; e.an = 3'b111; e.tick = 1'b0;
    q.push_back(e);
  endtask

  // Expected output for the first n cycles of a frame starting at cycle start.
  task automatic push_frame(input int start, input logic [6:0] g2, input logic [6:0] g1,
                            input logic [6:0] g0, input logic blank, input int n);
    for (int i = 0; i < n; i++) begin
      exp_t       e;
      int         s;
      int         k;
      logic [6:0] g;
      s = 2 - i / 8;
      k = i % 8;
      g = (s == 2) ? g2 : (s == 1) ? g1 : g0;
      if (s == 2 && blank && g2 == 7'h3F) g = 7'h00;
      e.cyc = start + i;
      if (k < 2) begin
        e.seg = 7'h7F; e.dp = 1'b1; e.an = 3'b111; e.tick = 1'b0;
      end else begin
        e.seg  = ~g;
        e.dp   = (s == 1) ? 1'b0 : 1'b1;
        e.an   = (s == 2) ? 3'b011 : (s == 1) ? 3'b101 : 3'b110;
        e.tick = (s == 0 && k == 7);
      end
      q.push_back(e);
    end
  endtask

  task automatic set_glyphs(input logic [6:0] g2, input logic [6:0] g1, input logic [6:0] g0);
    glyph[2] = g2; glyph[1] = g1; glyph[0] = g0;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: every output cycle is compared against the queued expectation for that cycle.
  always @(negedge clk) begin
    if (cyc >= WinLo && cyc <= WinHi) begin
      if ($countones(~an_out) > 1) multi_an++;
      if (frame_tick) ticks++;
    end
    while (q.size() > 0 && q[0].cyc < cyc) begin
      mon_e = q.pop_front();
      checks++;
      failures++;
      $display("FAIL missed cyc=%0d", mon_e.cyc);
    end
    if (q.size() > 0 && q[0].cyc == cyc) begin
      mon_e = q.pop_front();
      checks++;
      if ({seg_out, dp_out, an_out, frame_tick} !== {mon_e.seg, mon_e.dp, mon_e.an, mon_e.tick})
      begin
        failures++;
        $display("FAIL scan cyc=%0d got seg=%h dp=%b an=%b tick=%b want seg=%h dp=%b an=%b tick=%b",
                 cyc, seg_out, dp_out, an_out, frame_tick,
                 mon_e.seg, mon_e.dp, mon_e.an, mon_e.tick);
      end
    end
  end

  initial begin
    rst = 1'b1;
    enable = 1'b0;
    blank_leading = 1'b0;
    set_glyphs(7'h06, 7'h5B, 7'h4F);
    push_idle(1);
    push_idle(2);
    wait_cyc(2);
    rst = 1'b0;
    push_idle(3);
    wait_cyc(3);

    // Frames 1 and 2 show 1.2 3; glyphs change mid slot 1 of frame 2.
    enable = 1'b1;
    push_frame(4, 7'h06, 7'h5B, 7'h4F, 1'b0, 24);
    push_frame(28, 7'h06, 7'h5B, 7'h4F, 1'b0, 24);
    wait_cyc(40);
    set_glyphs(7'h66, 7'h6D, 7'h7D);
    push_frame(52, 7'h66, 7'h6D, 7'h7D, 1'b0, 24);

    // Leading-zero blanking, then unblanked zero.
    wait_cyc(57);
    set_glyphs(7'h3F, 7'h6D, 7'h7D);
    blank_leading = 1'b1;
    push_frame(76, 7'h3F, 7'h6D, 7'h7D, 1'b1, 24);
    wait_cyc(81);
    blank_leading = 1'b0;
    push_frame(100, 7'h3F, 7'h6D, 7'h7D, 1'b0, 24);

    // Enable drops during slot 0; frame is cut short and no tick appears.
    push_frame(124, 7'h3F, 7'h6D, 7'h7D, 1'b0, 20);
    push_idle(144);
    push_idle(145);
    wait_cyc(127);
    set_glyphs(7'h06, 7'h5B, 7'h4F);
    wait_cyc(143);
    enable = 1'b0;
    wait_cyc(145);
    enable = 1'b1;
    push_frame(146, 7'h06, 7'h5B, 7'h4F, 1'b0, 11);
    push_idle(157);
    push_idle(158);
    push_idle(159);

    // Asynchronous reset between edges during slot 1 ON.
    wait_cyc(157);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_seg", int'(seg_out), 32'h7F);
    chk("async_rst_dp", int'(dp_out), 1);
    chk("async_rst_an", int'(an_out), 7);
    chk("async_rst_tick", int'(frame_tick), 0);
    wait_cyc(159);
    rst = 1'b0;

    // Ten clean frames after release.
    for (int f = 0; f < 10; f++) begin
      push_frame(WinLo + 24 * f, 7'h06, 7'h5B, 7'h4F, 1'b0, 24);
    end
    wait_cyc(WinHi + 2);
    chk("queue_drained", q.size(), 0);
    chk("multi_anode", multi_an, 0);
    chk("frame_ticks", ticks, 10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
